// File: rtl/lvg_pkg.sv
// -----------------------------------------------------------------------------
// lvg_pkg
// Shared types and constants for the LVG 4x4 matrix dispatcher blocks.
//   LVG_WORD_W   : width of one dispatcher result word
//   LVG_LANES    : result words returned per dispatcher step (d1..d4)
//   LVG_COUNT_W  : width of the dispatcher `count` input
//   lvg_state_e  : sequencer states of lvg_dispatch_ctrl
//   lvg_result_t : one captured result beat {data, last}
// -----------------------------------------------------------------------------
package lvg_pkg;

  localparam int LVG_WORD_W  = 32;
  localparam int LVG_LANES   = 4;
  localparam int LVG_COUNT_W = 6;
  localparam int LVG_DATA_W  = LVG_WORD_W * LVG_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } lvg_state_e;

  // data is {d4,d3,d2,d1}; last marks the final beat of a command.
  typedef struct packed {
    logic [LVG_DATA_W-1:0] data;
    logic                  last;
  } lvg_result_t;

  localparam int LVG_RESULT_W = $bits(lvg_result_t);

endpackage

// File: rtl/lvg_sync_fifo.sv
// -----------------------------------------------------------------------------
// lvg_sync_fifo
// Single-clock FIFO used by the LVG stream blocks. The head entry is read
// straight from the storage registers, so out_valid rises the cycle after the
// first push into an empty FIFO (no fall-through path from i_data to o_data).
// Push and pop may happen in the same cycle at any fill level.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (empties the FIFO)
//   i_push   in   write i_data (ignored when full; overflow is asserted)
//   i_data   in   WIDTH-bit entry
//   i_pop    in   remove head entry (ignored when empty)
//   o_valid  out  head entry present
//   o_data   out  head entry, zero while empty
//   o_count  out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module lvg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && (r_count != '0);

  // Storage has no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  // Upstream credit logic must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/lvg_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// lvg_dispatch_ctrl
// Sequencer and output buffer for the LVG 4x4 matrix dispatcher. A single-beat
// command drives the dispatcher's count/shouldAdd for BEATS steps; the four
// returned words of every step are captured into a result FIFO and streamed out
// over valid/ready. The dispatcher cannot stall, so issue is credit based: a
// step is only issued while FIFO entries plus results still in flight inside
// the dispatcher are below FIFO_DEPTH, hence nothing is lost under backpressure.
//
// Optional feature: define LVG_DISPATCH_PERF_EN to add o_stall_cycles, a
// saturating count of ISSUE cycles without credit (cleared on command accept).
//
// Parameters:
//   BEATS      dispatcher steps per command, 1..63
//   LATENCY    cycles from count to matching d1..d4, 1..4
//   FIFO_DEPTH result FIFO entries, power of two >= 2
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   i_cmd_valid     in   command request
//   i_cmd_add       in   1 = add op, 0 = pass-through
//   o_cmd_ready     out  command accepted when valid && ready (IDLE only)
//   o_count         out  dispatcher count
//   o_should_add    out  dispatcher shouldAdd, held for the whole command
//   i_d1..i_d4      in   dispatcher result words
//   o_out_valid     out  result head valid
//   i_out_ready     in   consumer takes head
//   o_out_data      out  {d4,d3,d2,d1} of head
//   o_out_last      out  head is final beat of its command
//   o_busy          out  command in progress (accept .. last pop)
//   o_stall_cycles  out  (LVG_DISPATCH_PERF_EN only) no-credit ISSUE cycles
// -----------------------------------------------------------------------------
module lvg_dispatch_ctrl
  import lvg_pkg::*;
#(
  parameter int BEATS      = 4,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  input  logic                    i_cmd_add,
  output logic                    o_cmd_ready,
  output logic [LVG_COUNT_W-1:0]  o_count,
  output logic                    o_should_add,
  input  logic [LVG_WORD_W-1:0]   i_d1,
  input  logic [LVG_WORD_W-1:0]   i_d2,
  input  logic [LVG_WORD_W-1:0]   i_d3,
  input  logic [LVG_WORD_W-1:0]   i_d4,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [LVG_DATA_W-1:0]   o_out_data,
  output logic                    o_out_last,
  output logic                    o_busy
`ifdef LVG_DISPATCH_PERF_EN
  ,
  output logic [15:0]             o_stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVG_COUNT_W-1:0] LAST_BEAT = LVG_COUNT_W'(BEATS - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  lvg_state_e               r_state;
  lvg_state_e               w_state_next;
  logic [LVG_COUNT_W-1:0]   r_beat;
  logic                     r_should_add;
  logic                     r_pipe_vld  [LATENCY];
  logic                     r_pipe_last [LATENCY];
  logic [CW-1:0]            r_inflight;

  logic                     w_accept;
  logic                     w_issue;
  logic                     w_issue_last;
  logic                     w_cmd_ready;
  logic                     w_credit;
  logic [CW:0]              w_outstanding;
  logic                     w_exit;
  logic                     w_exit_last;
  logic                     w_pop;

  logic [CW-1:0]            w_fifo_count;
  logic                     w_fifo_valid;
  lvg_result_t              w_push_res;
  lvg_result_t              w_head;
  logic [LVG_WORD_W-1:0]    w_lanes [LVG_LANES];
  logic [LVG_DATA_W-1:0]    w_push_data;

  // Credit counts results already buffered plus those still inside the
  // dispatcher. Only registered values feed it, so a pop in this cycle frees
  // its slot for the next cycle, not this one.
  assign w_outstanding = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  assign w_credit      = (w_outstanding < (CW+1)'(FIFO_DEPTH));

  assign w_exit       = r_pipe_vld[LATENCY-1];
  assign w_exit_last  = r_pipe_last[LATENCY-1];
  assign w_issue_last = (r_beat == LAST_BEAT);
  assign w_pop        = w_fifo_valid && i_out_ready;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_cmd_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_issue_last) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The command ends when its final beat leaves the FIFO.
        if (w_pop && w_head.last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // beat doubles as the dispatcher count: it stays 0 in IDLE, advances only on
  // an issue and stops at the final beat so count never exceeds BEATS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat       <= '0;
      r_should_add <= 1'b0;
    end else if (w_accept) begin
      r_beat       <= '0;
      r_should_add <= i_cmd_add;
    end else if (w_issue && !w_issue_last) begin
      r_beat <= r_beat + 1'b1;
    end else if ((r_state == DRAIN) && (w_state_next == IDLE)) begin
      r_beat       <= '0;
      r_should_add <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight token pipe: mirrors the dispatcher latency so each token exits
  // exactly when its d1..d4 are valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_pipe_vld[k]  <= 1'b0;
        r_pipe_last[k] <= 1'b0;
      end
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_last[k] <= r_pipe_last[k-1];
      end
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && w_issue_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_exit})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture: lane j of the output word is dispatcher output d(j+1).
  // ---------------------------------------------------------------------------
  assign w_lanes[0] = i_d1;
  assign w_lanes[1] = i_d2;
  assign w_lanes[2] = i_d3;
  assign w_lanes[3] = i_d4;

  generate
    for (genvar gi = 0; gi < LVG_LANES; gi++) begin : g_lane
      assign w_push_data[gi*LVG_WORD_W +: LVG_WORD_W] = w_lanes[gi];
    end
  endgenerate

  assign w_push_res.data = w_push_data;
  assign w_push_res.last = w_exit_last;

  lvg_sync_fifo #(
    .WIDTH (LVG_RESULT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_exit),
    .i_data  (w_push_res),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef LVG_DISPATCH_PERF_EN
  logic        w_stall;
  logic [15:0] r_stall_cycles;

  assign w_stall = (r_state == ISSUE) && !w_credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cmd_ready  = w_cmd_ready;
  assign o_count      = r_beat;
  assign o_should_add = r_should_add;
  assign o_out_valid  = w_fifo_valid;
  assign o_out_data   = w_head.data;
  assign o_out_last   = w_head.last;
  assign o_busy       = (r_state != IDLE);

endmodule
